// File: rtl/spi_ctrl_pkg.sv
// Shared opcodes, FSM states, edge counts and transfer payload for spi_ram_ctrl.
// ST_DUMMY exists only when SPI_RAM_CTRL_QUAD_EN is defined.
package spi_ctrl_pkg;

  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_QREAD  = 8'h6B;
  localparam logic [7:0] CMD_QWRITE = 8'h32;

  localparam int unsigned EDGES_CMD_ADDR = 32;
  localparam int unsigned EDGES_SERIAL   = 40;
  localparam int unsigned EDGES_QWRITE   = 34;
  localparam int unsigned CNT_W          = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
`ifdef SPI_RAM_CTRL_QUAD_EN
    ST_DUMMY,
`endif
    ST_DATA,
    ST_DESEL
  } ctrl_state_e;

  typedef struct packed {
    logic        we;
    logic        quad;
    logic [23:0] addr;
    logic [7:0]  wdata;
  } xfer_t;

  function automatic logic [7:0] opcode(input logic we, input logic quad);
    if (quad) return we ? CMD_QWRITE : CMD_QREAD;
    return we ? CMD_WRITE : CMD_READ;
  endfunction

  // Index (0-based) of the final SCK edge of a transfer.
  function automatic logic [CNT_W-1:0] last_edge(input logic we, input logic quad,
                                                 input int unsigned quad_dummy);
    if (!quad) return CNT_W'(EDGES_SERIAL - 1);
    if (we) return CNT_W'(EDGES_QWRITE - 1);
    return CNT_W'(EDGES_QWRITE + quad_dummy - 1);
  endfunction

endpackage

// File: rtl/spi_ram_ctrl_if.sv
// One requester port of spi_ram_ctrl: request handshake plus completion response.
interface spi_req_if #(
  parameter int unsigned ADDR_BITS = 24
);
  logic                 valid;
  logic                 ready;
  logic                 we;
  logic                 quad;
  logic [ADDR_BITS-1:0] addr;
  logic [7:0]           wdata;
  logic                 rsp_valid;
  logic [7:0]           rsp_rdata;

  modport master (output valid, we, quad, addr, wdata, input ready, rsp_valid, rsp_rdata);
  modport slave  (input valid, we, quad, addr, wdata, output ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/spi_ctrl_arb.sv
// Two-input round-robin arbiter; on a tie the requester not granted last wins.
module spi_ctrl_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant_c
);
  logic last_grant;

  always_comb begin
    grant_c = 2'b00;
    if (en) begin
      case (valid)
        2'b01:   grant_c = 2'b01;
        2'b10:   grant_c = 2'b10;
        2'b11:   grant_c = last_grant ? 2'b01 : 2'b10;
        default: grant_c = 2'b00;
      endcase
    end
  end

  // Reset to 1 so req0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant <= 1'b1;
    else if (|grant_c) last_grant <= grant_c[1];
  end
endmodule

// File: rtl/spi_ram_ctrl.sv
// SPI/QSPI master sharing the spi_peri RAM between two single-byte requesters.
// Quad commands 6Bh/32h are built only with SPI_RAM_CTRL_QUAD_EN defined.
module spi_ram_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_BITS    = 24,
  parameter int unsigned SCK_HALF     = 1,
  parameter int unsigned QUAD_DUMMY   = 2,
  parameter int unsigned DESEL_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  spi_req_if.slave   req0,
  spi_req_if.slave   req1,
  output logic       spi_clk,
  output logic       spi_select,
  output logic [3:0] spi_d_out,
  output logic [3:0] spi_d_oe,
  input  logic [3:0] spi_d_in,
  output logic       busy
);
  localparam int unsigned HALF_W  = $clog2(SCK_HALF) + 1;
  localparam int unsigned DESEL_W = $clog2(DESEL_CYCLES) + 1;

  ctrl_state_e          state, st_nxt;
  logic [HALF_W-1:0]    half_cnt;
  logic                 high, start_q, half_end, sample_now;
  logic [CNT_W-1:0]     bit_cnt, bit_last, bit_nxt;
  logic [39:0]          sr, sr_nxt;
  logic                 we_q, quad_q, sel_q;
  logic [7:0]           rd_sr, rd_sampled, rd_final;
  logic [DESEL_W-1:0]   desel_cnt;
  logic [1:0]           grant_c;
  logic [ADDR_BITS-1:0] g_addr;
  xfer_t                g;
  logic [3:0]           out_nxt, oe_nxt;

  spi_ctrl_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (state == ST_IDLE),
    .valid   ({req1.valid, req0.valid}),
    .grant_c (grant_c)
  );

  always_comb begin  // payload of the requester being granted
    g_addr  = grant_c[1] ? req1.addr : req0.addr;
    g.we    = grant_c[1] ? req1.we : req0.we;
`ifdef SPI_RAM_CTRL_QUAD_EN
    g.quad  = grant_c[1] ? req1.quad : req0.quad;
`else
    g.quad  = 1'b0;
`endif
    g.addr  = 24'(g_addr);
    g.wdata = g.we ? (grant_c[1] ? req1.wdata : req0.wdata) : 8'h00;
  end

  always_comb begin
    half_end   = (half_cnt == HALF_W'(SCK_HALF - 1));
    sample_now = high && (half_cnt == '0) && (state == ST_DATA) && !we_q;
    rd_sampled = quad_q ? {rd_sr[3:0], spi_d_in} : {rd_sr[6:0], spi_d_in[1]};
    rd_final   = we_q ? 8'h00 : (sample_now ? rd_sampled : rd_sr);
    bit_nxt    = bit_cnt + CNT_W'(1);
    // Quad write data leaves a nibble per edge once the address is out.
    sr_nxt     = (quad_q && bit_cnt >= CNT_W'(EDGES_CMD_ADDR)) ? {sr[35:0], 4'h0}
                                                               : {sr[38:0], 1'b0};
    out_nxt    = {3'b000, sr_nxt[39]};
    oe_nxt     = 4'b0001;
    st_nxt     = ST_SHIFT;
    if (bit_nxt >= CNT_W'(EDGES_CMD_ADDR)) begin
      st_nxt = ST_DATA;
      if (quad_q) begin
        if (we_q) begin
          out_nxt = sr_nxt[39:36];
          oe_nxt  = 4'b1111;
        end else begin
          out_nxt = 4'h0;
          oe_nxt  = 4'h0;
`ifdef SPI_RAM_CTRL_QUAD_EN
          if (bit_nxt < CNT_W'(EDGES_CMD_ADDR + QUAD_DUMMY)) st_nxt = ST_DUMMY;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      half_cnt       <= '0;
      high           <= 1'b0;
      start_q        <= 1'b0;
      bit_cnt        <= '0;
      bit_last       <= '0;
      sr             <= '0;
      we_q           <= 1'b0;
      quad_q         <= 1'b0;
      sel_q          <= 1'b0;
      rd_sr          <= '0;
      desel_cnt      <= '0;
      spi_clk        <= 1'b0;
      spi_select     <= 1'b1;
      spi_d_out      <= '0;
      spi_d_oe       <= '0;
      busy           <= 1'b0;
      req0.ready     <= 1'b0;
      req1.ready     <= 1'b0;
      req0.rsp_valid <= 1'b0;
      req1.rsp_valid <= 1'b0;
      req0.rsp_rdata <= '0;
      req1.rsp_rdata <= '0;
    end else begin
      req0.ready     <= 1'b0;
      req1.ready     <= 1'b0;
      req0.rsp_valid <= 1'b0;
      req1.rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|grant_c) begin
            req0.ready <= grant_c[0];
            req1.ready <= grant_c[1];
            sel_q      <= grant_c[1];
            we_q       <= g.we;
            quad_q     <= g.quad;
            sr         <= {opcode(g.we, g.quad), g.addr, g.wdata};
            bit_last   <= last_edge(g.we, g.quad, QUAD_DUMMY);
            bit_cnt    <= '0;
            half_cnt   <= '0;
            high       <= 1'b0;
            rd_sr      <= '0;
            start_q    <= 1'b1;
            busy       <= 1'b1;
            state      <= ST_SHIFT;
          end
        end
        ST_DESEL: begin
          if (desel_cnt == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            desel_cnt <= desel_cnt - DESEL_W'(1);
          end
        end
        default: begin
          // Grant cycle is spent setting up the first low phase.
          if (start_q) begin
            start_q    <= 1'b0;
            spi_select <= 1'b0;
            spi_d_out  <= {3'b000, sr[39]};
            spi_d_oe   <= 4'b0001;
          end else begin
            if (sample_now) rd_sr <= rd_sampled;
            half_cnt <= half_end ? '0 : half_cnt + HALF_W'(1);
            if (half_end && !high) begin
              high    <= 1'b1;
              spi_clk <= 1'b1;
            end else if (half_end && high) begin
              high    <= 1'b0;
              spi_clk <= 1'b0;
              if (bit_cnt == bit_last) begin
                spi_select <= 1'b1;
                spi_d_out  <= '0;
                spi_d_oe   <= '0;
                desel_cnt  <= DESEL_W'(DESEL_CYCLES - 1);
                state      <= ST_DESEL;
                if (sel_q) begin
                  req1.rsp_valid <= 1'b1;
                  req1.rsp_rdata <= rd_final;
                end else begin
                  req0.rsp_valid <= 1'b1;
                  req0.rsp_rdata <= rd_final;
                end
              end else begin
                bit_cnt   <= bit_nxt;
                sr        <= sr_nxt;
                spi_d_out <= out_nxt;
                spi_d_oe  <= oe_nxt;
                state     <= st_nxt;
              end
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl with a behavioural spi_peri RAM slave.
// Expectations follow SPI_RAM_CTRL_QUAD_EN when it is defined.
module tb_spi_ram_ctrl;
  localparam int QD = 2;
`ifdef SPI_RAM_CTRL_QUAD_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_clk, spi_select, busy;
  logic [3:0] spi_d_out, spi_d_oe;
  logic [3:0] spi_d_in = 4'h0;

  spi_req_if #(.ADDR_BITS(24)) r0 ();
  spi_req_if #(.ADDR_BITS(24)) r1 ();

  spi_ram_ctrl #(.ADDR_BITS(24), .SCK_HALF(1), .QUAD_DUMMY(QD), .DESEL_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req0(r0), .req1(r1),
    .spi_clk(spi_clk), .spi_select(spi_select), .spi_d_out(spi_d_out),
    .spi_d_oe(spi_d_oe), .spi_d_in(spi_d_in), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rsp0_cnt = 0;
  int rsp1_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (r0.rsp_valid) rsp0_cnt++;
    if (r1.rsp_valid) rsp1_cnt++;
  end

  // Behavioural RAM slave: mode 0, captures on rising SCK, drives on falling SCK.
  logic [7:0]  mem [0:255];
  logic [7:0]  cmd, wbyte, last_cmd, rb;
  logic [23:0] addr, last_addr;
  logic [3:0]  oe_log [0:63];
  logic [3:0]  d_log  [0:63];
  int          ec = 0;
  int          last_edges = 0;

  always @(posedge spi_clk or posedge spi_select) begin
    if (spi_select) begin
      if (ec > 0) begin
        last_edges = ec;
        last_cmd   = cmd;
        last_addr  = addr;
        if ((cmd == 8'h02 && ec == 40) || (cmd == 8'h32 && ec == 34)) mem[addr[7:0]] = wbyte;
      end
      ec = 0;
    end else begin
      ec = ec + 1;
      if (ec < 64) begin
        oe_log[ec] = spi_d_oe;
        d_log[ec]  = spi_d_out;
      end
      if (ec <= 8) cmd = {cmd[6:0], spi_d_out[0]};
      else if (ec <= 32) addr = {addr[22:0], spi_d_out[0]};
      else if (cmd == 8'h02) wbyte = {wbyte[6:0], spi_d_out[0]};
      else if (cmd == 8'h32) wbyte = {wbyte[3:0], spi_d_out};
    end
  end

  always @(negedge spi_clk) begin
    if (!spi_select) begin
      rb = mem[addr[7:0]];
      spi_d_in = 4'h0;
      if (cmd == 8'h03 && ec >= 32 && ec < 40) spi_d_in[1] = rb[39-ec];
      else if (cmd == 8'h6B && ec == 32 + QD) spi_d_in = rb[7:4];
      else if (cmd == 8'h6B && ec == 33 + QD) spi_d_in = rb[3:0];
    end
  end

  // One request on port id; lat is cycles from the ready pulse to the rsp pulse.
  task automatic do_req(input int id, input logic we, input logic quad, input logic [23:0] a,
                        input logic [7:0] wd, output logic [7:0] rd, output int lat, output bit ok);
    int t0 = -1;
    ok  = 1'b0;
    lat = 0;
    rd  = 8'hxx;
    @(negedge clk);
    if (id == 0) begin r0.we = we; r0.quad = quad; r0.addr = a; r0.wdata = wd; r0.valid = 1'b1; end
    else begin r1.we = we; r1.quad = quad; r1.addr = a; r1.wdata = wd; r1.valid = 1'b1; end
    for (int i = 0; i < 200 && t0 < 0; i++) begin
      @(negedge clk);
      if (id == 0 && r0.ready) begin t0 = cyc; r0.valid = 1'b0; end
      if (id == 1 && r1.ready) begin t0 = cyc; r1.valid = 1'b0; end
    end
    if (t0 < 0) return;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (id == 0 && r0.rsp_valid) begin rd = r0.rsp_rdata; ok = 1'b1; end
      if (id == 1 && r1.rsp_valid) begin rd = r1.rsp_rdata; ok = 1'b1; end
      if (ok) begin lat = cyc - t0; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (spi_select !== 1'b1) begin errors++; $display("FAIL reset_select: got %b expected 1", spi_select); end
    checks++; if (spi_clk !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b expected 0", spi_clk); end
    checks++; if ({spi_d_out, spi_d_oe} !== 8'h00) begin errors++; $display("FAIL reset_lanes: got %h expected 00", {spi_d_out, spi_d_oe}); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({busy, r0.ready, r1.ready, r0.rsp_valid, r1.rsp_valid} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, r0.ready, r1.ready, r0.rsp_valid, r1.rsp_valid}); end
    checks++; if ({r0.rsp_rdata, r1.rsp_rdata} !== 16'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0000", {r0.rsp_rdata, r1.rsp_rdata}); end
  endtask

  task automatic test_arbitration();
    int order[$];
    int n0 = rsp0_cnt;
    int n1 = rsp1_cnt;
    @(negedge clk);
    r0.we = 1'b0; r0.quad = 1'b0; r0.addr = 24'd0;
    r1.we = 1'b0; r1.quad = 1'b0; r1.addr = 24'd1;
    r0.valid = 1'b1; r1.valid = 1'b1;
    for (int i = 0; i < 2000 && order.size() < 4; i++) begin
      @(negedge clk);
      if (r0.ready) order.push_back(0);
      if (r1.ready) order.push_back(1);
    end
    r0.valid = 1'b0; r1.valid = 1'b0;
    for (int i = 0; i < 400; i++) begin @(negedge clk); if (!busy) break; end
    checks++; if (order.size() != 4) begin errors++; $display("FAIL arb_grant_count: got %0d expected 4", order.size()); end
    for (int k = 0; k < order.size(); k++) begin
      checks++; if (order[k] != k % 2) begin errors++; $display("FAIL arb_order[%0d]: got %0d expected %0d", k, order[k], k % 2); end
    end
    checks++; if (rsp0_cnt - n0 != 2 || rsp1_cnt - n1 != 2) begin
      errors++; $display("FAIL arb_rsp_counts: got %0d/%0d expected 2/2", rsp0_cnt - n0, rsp1_cnt - n1); end
  endtask

  task automatic test_serial_read();
    logic [7:0] rd; int lat; bit ok;
    do_req(0, 1'b0, 1'b0, 24'h000005, 8'h00, rd, lat, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sread_done: got timeout expected rsp0"); end
    checks++; if (rd !== 8'h5A) begin errors++; $display("FAIL sread_data: got %h expected 5a", rd); end
    checks++; if (lat != 81) begin errors++; $display("FAIL sread_latency: got %0d expected 81", lat); end
    checks++; if ({last_cmd, last_addr} !== 32'h03000005) begin errors++; $display("FAIL sread_cmd_addr: got %h expected 03000005", {last_cmd, last_addr}); end
    checks++; if (last_edges != 40) begin errors++; $display("FAIL sread_edges: got %0d expected 40", last_edges); end
    checks++; if ({oe_log[1], oe_log[32], oe_log[33], d_log[33]} !== 16'h1110) begin
      errors++; $display("FAIL sread_lanes: got %h expected 1110", {oe_log[1], oe_log[32], oe_log[33], d_log[33]}); end
  endtask

  task automatic test_serial_write_read();
    logic [7:0] rd; int lat; bit ok;
    do_req(1, 1'b1, 1'b0, 24'h000003, 8'hA5, rd, lat, ok);
    checks++; if (!ok || rd !== 8'h00) begin errors++; $display("FAIL swrite_rsp: got ok=%0d rdata=%h expected 1/00", ok, rd); end
    checks++; if (last_cmd !== 8'h02 || last_edges != 40) begin errors++; $display("FAIL swrite_cmd: got %h/%0d expected 02/40", last_cmd, last_edges); end
    checks++; if (mem[3] !== 8'hA5) begin errors++; $display("FAIL swrite_mem: got %h expected a5", mem[3]); end
    checks++; if (lat != 81) begin errors++; $display("FAIL swrite_latency: got %0d expected 81", lat); end
    do_req(1, 1'b0, 1'b0, 24'h000003, 8'h00, rd, lat, ok);
    checks++; if (!ok || rd !== 8'hA5) begin errors++; $display("FAIL sreadback: got ok=%0d rdata=%h expected 1/a5", ok, rd); end
    checks++; if (last_edges != 40) begin errors++; $display("FAIL sreadback_edges: got %0d expected 40", last_edges); end
  endtask

  task automatic test_quad();
    logic [7:0] rd; int lat; bit ok;
    do_req(0, 1'b1, 1'b1, 24'h000002, 8'h3C, rd, lat, ok);
    checks++; if (!ok) begin errors++; $display("FAIL qwrite_done: got timeout expected rsp0"); end
    checks++; if (last_cmd !== (QEN ? 8'h32 : 8'h02)) begin errors++; $display("FAIL qwrite_cmd: got %h expected %h", last_cmd, QEN ? 8'h32 : 8'h02); end
    checks++; if (last_edges != (QEN ? 34 : 40)) begin errors++; $display("FAIL qwrite_edges: got %0d expected %0d", last_edges, QEN ? 34 : 40); end
    checks++; if ({oe_log[33], oe_log[34]} !== (QEN ? 8'hFF : 8'h11)) begin
      errors++; $display("FAIL qwrite_oe: got %h expected %h", {oe_log[33], oe_log[34]}, QEN ? 8'hFF : 8'h11); end
    checks++; if ({d_log[33], d_log[34]} !== (QEN ? 8'h3C : 8'h00)) begin
      errors++; $display("FAIL qwrite_nibbles: got %h expected %h", {d_log[33], d_log[34]}, QEN ? 8'h3C : 8'h00); end
    checks++; if (lat != (QEN ? 69 : 81)) begin errors++; $display("FAIL qwrite_latency: got %0d expected %0d", lat, QEN ? 69 : 81); end
    checks++; if (mem[2] !== 8'h3C) begin errors++; $display("FAIL qwrite_mem: got %h expected 3c", mem[2]); end
    do_req(0, 1'b0, 1'b1, 24'h000002, 8'h00, rd, lat, ok);
    checks++; if (!ok || rd !== 8'h3C) begin errors++; $display("FAIL qread_data: got ok=%0d rdata=%h expected 1/3c", ok, rd); end
    checks++; if (last_cmd !== (QEN ? 8'h6B : 8'h03)) begin errors++; $display("FAIL qread_cmd: got %h expected %h", last_cmd, QEN ? 8'h6B : 8'h03); end
    checks++; if (last_edges != (QEN ? 34 + QD : 40)) begin errors++; $display("FAIL qread_edges: got %0d expected %0d", last_edges, QEN ? 34 + QD : 40); end
    checks++; if (lat != (QEN ? 73 : 81)) begin errors++; $display("FAIL qread_latency: got %0d expected %0d", lat, QEN ? 73 : 81); end
    checks++; if ({oe_log[32], oe_log[33], oe_log[36]} !== (QEN ? 12'h100 : 12'h111)) begin
      errors++; $display("FAIL qread_oe: got %h expected %h", {oe_log[32], oe_log[33], oe_log[36]}, QEN ? 12'h100 : 12'h111); end
  endtask

  task automatic test_reset_abort();
    logic [7:0] rd; int lat; bit ok;
    int n0;
    bit hit = 1'b0;
    @(negedge clk);
    r0.we = 1'b0; r0.quad = 1'b0; r0.addr = 24'h000005; r0.valid = 1'b1;
    n0 = rsp0_cnt;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge clk);
      if (r0.ready) r0.valid = 1'b0;
      if (ec >= 20) hit = 1'b1;
    end
    checks++; if (!hit) begin errors++; $display("FAIL abort_reach_edge20: got ec=%0d expected 20", ec); end
    r0.valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if ({spi_select, spi_clk, spi_d_oe} !== 6'b100000) begin
      errors++; $display("FAIL abort_pins: got %b expected 100000", {spi_select, spi_clk, spi_d_oe}); end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (rsp0_cnt != n0 || busy !== 1'b0) begin errors++; $display("FAIL abort_no_rsp: got rsp=%0d busy=%b expected 0/0", rsp0_cnt - n0, busy); end
    checks++; if (last_edges != 20) begin errors++; $display("FAIL abort_edges: got %0d expected 20", last_edges); end
    do_req(1, 1'b0, 1'b0, 24'h000003, 8'h00, rd, lat, ok);
    checks++; if (!ok || rd !== 8'hA5 || lat != 81) begin
      errors++; $display("FAIL abort_recover: got ok=%0d rdata=%h lat=%0d expected 1/a5/81", ok, rd, lat); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[5] = 8'h5A;
    r0.valid = 1'b0; r0.we = 1'b0; r0.quad = 1'b0; r0.addr = '0; r0.wdata = '0;
    r1.valid = 1'b0; r1.we = 1'b0; r1.quad = 1'b0; r1.addr = '0; r1.wdata = '0;
    test_reset();
    test_arbitration();
    test_serial_read();
    test_serial_write_read();
    test_quad();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
